// File: rtl/memgame_pkg.sv
// Shared definitions for the memory-game card dealer: palette, FSM encoding, LFSR constants.
package memgame_pkg;

    localparam int COLOR_W  = 12;
    localparam int N_COLORS = 8;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK    = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SHUFFLE,
        ST_WRITE,
        ST_DONE
    } state_t;

    // {r,g,b}, 4 bits per channel: RED, GREEN, BLUE, CYAN, MAGENTA, YELLOW, WHITE, MINT
    localparam logic [COLOR_W-1:0] PALETTE [N_COLORS] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'h0FF,
        12'hF0F, 12'hFF0, 12'hFFF, 12'h8FC
    };

    // Galois right-shift step
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return (q >> 1) ^ (q[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR; a zero seed is replaced by the default so the register never locks up.
module lfsr16
    import memgame_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= DEFAULT_SEED;
        end else if (load) begin
            q <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/deal_cards.sv
// Fills a deck with colour pairs, Fisher-Yates shuffles it with an LFSR, and writes it
// out to consecutive register-file addresses.
module deal_cards
    import memgame_pkg::*;
#(
    parameter int N_PAIRS   = 6,
    parameter int ADDR_W    = 4,
    parameter int BASE_ADDR = 1,
    parameter int COLOR_W   = memgame_pkg::COLOR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          seed,
    output logic                 busy,
    output logic                 done,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [COLOR_W+1:0]   wr_data
);

    localparam int DECK_N = 2 * N_PAIRS;
    localparam int IDX_W  = $clog2(DECK_N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DECK_N - 1);

    if (N_PAIRS < 1 || N_PAIRS > 8) begin : g_bad_pairs
        $error("deal_cards: N_PAIRS must be in 1..8");
    end
    if (BASE_ADDR + DECK_N - 1 > (1 << ADDR_W) - 1) begin : g_bad_addr
        $error("deal_cards: deck does not fit in the register-file address space");
    end

    state_t             state, state_n;
    logic [IDX_W-1:0]   k;
    logic [IDX_W-1:0]   i;
    logic [IDX_W-1:0]   j;
    logic [15:0]        lfsr_q;
    logic               accept;
    logic               swap;
    logic [COLOR_W-1:0] deck [DECK_N];

    assign accept = (state == ST_IDLE) && start;
    assign j      = lfsr_q[IDX_W-1:0];
    assign swap   = (state == ST_SHUFFLE) && (j <= i);

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .seed (seed),
        .step (state == ST_SHUFFLE),
        .q    (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (start) state_n = ST_FILL;
            ST_FILL:    if (k == LAST) state_n = ST_SHUFFLE;
            ST_SHUFFLE: if (swap && i == IDX_W'(1)) state_n = ST_WRITE;
            ST_WRITE:   if (k == LAST) state_n = ST_DONE;
            ST_DONE:    state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    // k walks the deck in FILL and WRITE; i is the Fisher-Yates upper bound
    always_ff @(posedge clk) begin
        if (rst) begin
            k <= '0;
            i <= '0;
        end else begin
            if (state == ST_FILL || state == ST_WRITE) begin
                k <= (k == LAST) ? '0 : k + IDX_W'(1);
            end else begin
                k <= '0;
            end
            if (accept) begin
                i <= LAST;
            end else if (swap) begin
                i <= i - IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_FILL) begin
            deck[k] <= COLOR_W'(PALETTE[3'(k >> 1)]);
        end else if (swap) begin
            deck[i] <= deck[j];
            deck[j] <= deck[i];
        end
    end

    // Registered outputs lag the state by one cycle, so done lands after the last write
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            busy  <= (state_n != ST_IDLE);
            done  <= (state == ST_DONE);
            wr_en <= (state == ST_WRITE);
            if (state == ST_WRITE) begin
                wr_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(k);
                wr_data <= {deck[k], 1'b0, 1'b1};
            end else begin
                wr_addr <= '0;
                wr_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_deal_cards.sv
// Self-checking bench for deal_cards: three parameterisations, table-driven deals,
// reset/start-injection corner cases and randomized seeds against a shuffle model.
module tb_deal_cards;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] seed;
    int          sel;

    logic        busy_v    [3];
    logic        done_v    [3];
    logic        wr_en_v   [3];
    logic [3:0]  wr_addr_v [3];
    logic [13:0] wr_data_v [3];
    logic        start0, start1, start2;

    logic        m_busy, m_done, m_wr_en;
    logic [3:0]  m_addr;
    logic [13:0] m_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] pal [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'h0FF,
                             12'hF0F, 12'hFF0, 12'hFFF, 12'h8FC};
    logic [11:0] exp_deck [16];
    logic [13:0] last_seq [16];
    logic [13:0] hist     [8][16];
    int          last_n;

    always #5 clk = ~clk;

    assign start0 = start && (sel == 0);
    assign start1 = start && (sel == 1);
    assign start2 = start && (sel == 2);
    assign m_busy  = busy_v[sel];
    assign m_done  = done_v[sel];
    assign m_wr_en = wr_en_v[sel];
    assign m_addr  = wr_addr_v[sel];
    assign m_data  = wr_data_v[sel];

    deal_cards #(.N_PAIRS(6), .ADDR_W(4), .BASE_ADDR(1), .COLOR_W(12)) dut6 (
        .clk(clk), .rst(rst), .start(start0), .seed(seed),
        .busy(busy_v[0]), .done(done_v[0]), .wr_en(wr_en_v[0]),
        .wr_addr(wr_addr_v[0]), .wr_data(wr_data_v[0]));

    deal_cards #(.N_PAIRS(1), .ADDR_W(4), .BASE_ADDR(1), .COLOR_W(12)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .seed(seed),
        .busy(busy_v[1]), .done(done_v[1]), .wr_en(wr_en_v[1]),
        .wr_addr(wr_addr_v[1]), .wr_data(wr_data_v[1]));

    deal_cards #(.N_PAIRS(8), .ADDR_W(4), .BASE_ADDR(0), .COLOR_W(12)) dut8 (
        .clk(clk), .rst(rst), .start(start2), .seed(seed),
        .busy(busy_v[2]), .done(done_v[2]), .wr_en(wr_en_v[2]),
        .wr_addr(wr_addr_v[2]), .wr_data(wr_data_v[2]));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference shuffle: fill pairs, then Fisher-Yates with rejection sampling on the LFSR
    task automatic build_model(input int np, input logic [15:0] sd);
        logic [15:0] l;
        logic [11:0] t;
        int n, w, ii, jj;
        n  = 2 * np;
        w  = $clog2(n);
        l  = (sd == 16'h0000) ? 16'hACE1 : sd;
        for (int c = 0; c < 16; c++) exp_deck[c] = 12'h000;
        for (int c = 0; c < n; c++) exp_deck[c] = pal[c / 2];
        ii = n - 1;
        while (ii >= 1) begin
            jj = int'(l) % (1 << w);
            l  = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
            if (jj <= ii) begin
                t = exp_deck[ii];
                exp_deck[ii] = exp_deck[jj];
                exp_deck[jj] = t;
                ii--;
            end
        end
    endtask

    function automatic int np_of(input int s);
        return (s == 0) ? 6 : (s == 1) ? 1 : 8;
    endfunction

    function automatic int base_of(input int s);
        return (s == 2) ? 0 : 1;
    endfunction

    // mode 0: plain deal; mode 1: start held high on every busy cycle
    task automatic run_deal(input int s, input logic [15:0] sd, input int mode,
                            input int exp_n, input int exp_first, input int exp_last);
        int np, base, cyc, first_a, last_a, cnt;
        np = np_of(s);
        base = base_of(s);
        build_model(np, sd);
        sel = s;
        seed = sd;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seed = 16'($urandom);
        chk("busy_after_start", 32'(m_busy), 32'd1);
        last_n = 0; cyc = 0; first_a = -1; last_a = -1;
        while (cyc < 3000 && !m_done) begin
            if (m_wr_en) begin
                if (last_n < 16) begin
                    last_seq[last_n] = m_data;
                    chk("wr_addr", 32'(m_addr), 32'(base + last_n));
                    chk("wr_data", 32'(m_data), 32'({exp_deck[last_n], 2'b01}));
                end
                if (first_a < 0) first_a = int'(m_addr);
                last_a = int'(m_addr);
                last_n++;
            end
            start = (mode == 1) && m_busy;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", 32'(m_done), 32'd1);
        chk("write_count", 32'(last_n), 32'(exp_n));
        chk("first_addr", 32'(first_a), 32'(exp_first));
        chk("last_addr", 32'(last_a), 32'(exp_last));
        chk("busy_at_done", 32'(m_busy), 32'd0);
        chk("wr_en_at_done", 32'(m_wr_en), 32'd0);
        for (int c = 0; c < 8; c++) begin
            cnt = 0;
            for (int q = 0; q < last_n && q < 16; q++)
                if (last_seq[q][13:2] == pal[c]) cnt++;
            chk("colour_pair_count", 32'(cnt), (c < np) ? 32'd2 : 32'd0);
        end
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(m_done), 32'd0);
        cnt = 0;
        repeat (4) begin
            if (m_wr_en) cnt++;
            @(posedge clk); #1;
        end
        chk("no_write_after_done", 32'(cnt), 32'd0);
    endtask

    typedef struct {
        int          s;
        logic [15:0] sd;
        int          mode;
        int          exp_n;
        int          exp_first;
        int          exp_last;
    } vec_t;

    vec_t vt [7];

    initial begin
        int same, cnt, nd, cyc;
        vt[0] = '{0, 16'h1234, 0, 12, 1, 12};
        vt[1] = '{0, 16'h1234, 0, 12, 1, 12};
        vt[2] = '{0, 16'h0000, 0, 12, 1, 12};
        vt[3] = '{0, 16'hACE1, 0, 12, 1, 12};
        vt[4] = '{0, 16'h5A5A, 1, 12, 1, 12};
        vt[5] = '{1, 16'h00FF, 0, 2, 1, 2};
        vt[6] = '{2, 16'hBEEF, 0, 16, 0, 15};

        rst = 1'b1; start = 1'b0; seed = 16'h0000; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_busy", 32'(busy_v[d]), 32'd0);
            chk("rst_done", 32'(done_v[d]), 32'd0);
            chk("rst_wr_en", 32'(wr_en_v[d]), 32'd0);
            chk("rst_wr_addr", 32'(wr_addr_v[d]), 32'd0);
            chk("rst_wr_data", 32'(wr_data_v[d]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 7; t++) begin
            run_deal(vt[t].s, vt[t].sd, vt[t].mode, vt[t].exp_n, vt[t].exp_first, vt[t].exp_last);
            for (int q = 0; q < 16; q++) hist[t][q] = last_seq[q];
        end

        same = 1;
        for (int q = 0; q < 12; q++) if (hist[0][q] !== hist[1][q]) same = 0;
        chk("same_seed_repeat", 32'(same), 32'd1);
        same = 1;
        for (int q = 0; q < 12; q++) if (hist[2][q] !== hist[3][q]) same = 0;
        chk("zero_seed_is_default", 32'(same), 32'd1);

        // Reset on the 5th write: outputs clear next cycle and the deal is abandoned
        sel = 0; seed = 16'h4321; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0; cyc = 0;
        while (cyc < 3000 && cnt < 5) begin
            if (m_wr_en) cnt++;
            if (cnt < 5) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("reached_5th_write", 32'(cnt), 32'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_wr_en", 32'(m_wr_en), 32'd0);
        chk("rst_mid_busy", 32'(m_busy), 32'd0);
        cnt = 0; nd = 0;
        repeat (40) begin
            if (m_wr_en) cnt++;
            if (m_done) nd++;
            @(posedge clk); #1;
        end
        chk("rst_mid_no_writes", 32'(cnt), 32'd0);
        chk("rst_mid_no_done", 32'(nd), 32'd0);
        run_deal(0, 16'h4321, 0, 12, 1, 12);

        for (int r = 0; r < 6; r++) begin
            int s;
            s = int'($urandom_range(0, 2));
            run_deal(s, 16'($urandom), int'($urandom_range(0, 1)),
                     2 * np_of(s), base_of(s), base_of(s) + 2 * np_of(s) - 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
